// File: rtl/inject_arbiter_if.sv
// Requester-side and node-side signals of the injection port arbiter.
// The arbiter connects through the slave modport; the requester/node environment uses master.
interface inject_arbiter_if #(
    parameter int FLIT_SIZE = 82,
    parameter int N_REQ     = 4,
    parameter int CREDITS   = 4
);
    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(CREDITS + 1);

    logic [N_REQ-1:0]                 req_valid;
    logic [N_REQ*(FLIT_SIZE+1)-1:0]   req_flit;
    logic [N_REQ-1:0]                 req_ready;
    logic [FLIT_SIZE:0]               inject_flit;
    logic                             credit_ret;
    logic [GW-1:0]                    grant_id;
    logic                             busy;
    logic [CW-1:0]                    credit_cnt;
    logic                             err_credit_ovf;

    modport master (
        output req_valid, req_flit, credit_ret,
        input  req_ready, inject_flit, grant_id, busy, credit_cnt, err_credit_ovf
    );

    modport slave (
        input  req_valid, req_flit, credit_ret,
        output req_ready, inject_flit, grant_id, busy, credit_cnt, err_credit_ovf
    );
endinterface

// File: rtl/inject_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one node injection port among N_REQ requesters,
// with credit-based flow control towards the node injection buffer and a registered flit output.
module inject_arbiter #(
    parameter int FLIT_SIZE = 82,
    parameter int N_REQ     = 4,
    parameter int CREDITS   = 4
) (
    input  logic            clk,
    input  logic            rst,
    inject_arbiter_if.slave bus
);
    localparam int          FW = FLIT_SIZE + 1;
    localparam int          GW = $clog2(N_REQ);
    localparam int          CW = $clog2(CREDITS + 1);
    localparam int unsigned NR = N_REQ;

    typedef enum logic {IDLE, LOCK} state_e;

    state_e             state_q, state_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic [GW-1:0]      rr_q, rr_d;
    logic [CW-1:0]      credit_q, credit_d;
    logic [FLIT_SIZE:0] flit_q, flit_d;
    logic [N_REQ-1:0]   ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic [FLIT_SIZE:0] sel_flit;
    logic               xfer;
    logic               found;
    logic [GW-1:0]      winner;
    int unsigned        idx;

    always_comb begin
        sel_flit = bus.req_flit[int'(grant_q)*FW +: FW];
        // ready_q is only ever set for the granted requester while in LOCK
        xfer     = ready_q[grant_q] & bus.req_valid[grant_q];

        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned k = 1; k <= NR; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= NR) idx = idx - NR;
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = GW'(idx);
            end
        end

        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        flit_d   = '0;
        credit_d = credit_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = LOCK;
                    grant_d = winner;
                end
            end
            LOCK: begin
                if (xfer) begin
                    flit_d            = sel_flit;
                    flit_d[FLIT_SIZE] = 1'b1;
                    if (sel_flit[FLIT_SIZE-1]) begin
                        state_d = IDLE;
                        rr_d    = grant_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (xfer && !bus.credit_ret) begin
            credit_d = credit_q - 1'b1;
        end else if (!xfer && bus.credit_ret) begin
            if (credit_q == CW'(CREDITS)) err_d = 1'b1;
            else credit_d = credit_q + 1'b1;
        end

        // Ready and busy are computed from next-state values so they can be registered
        busy_d  = (state_d == LOCK);
        ready_d = '0;
        if (state_d == LOCK && credit_d != '0) ready_d[grant_d] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_q     <= GW'(N_REQ - 1);
            credit_q <= CW'(CREDITS);
            flit_q   <= '0;
            ready_q  <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            credit_q <= credit_d;
            flit_q   <= flit_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign bus.req_ready      = ready_q;
    assign bus.inject_flit    = flit_q;
    assign bus.grant_id       = grant_q;
    assign bus.busy           = busy_q;
    assign bus.credit_cnt     = credit_q;
    assign bus.err_credit_ovf = err_q;
endmodule

// File: tb/tb_inject_arbiter.sv
// Directed bench for inject_arbiter: accepted flits are queued as expectations and
// matched against inject_flit, plus explicit checks of reset, ordering, timing and credits.
module tb_inject_arbiter;
    localparam int FS = 82;
    localparam int N  = 4;
    localparam int C  = 4;
    localparam int FW = FS + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inject_arbiter_if #(.FLIT_SIZE(FS), .N_REQ(N), .CREDITS(C)) bus();
    inject_arbiter #(.FLIT_SIZE(FS), .N_REQ(N), .CREDITS(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;
    int nout = 0;
    logic [FS:0] exp_q[$];
    logic [FS:0] mon_e;
    int out_src[$];
    int out_cyc[$];
    int plen[N], npk[N], idx[N], gap[N], seq[N];
    bit bub[N];
    bit auto_ret;
    int base, t0;
    int exp3[5] = '{0, 1, 2, 3, 0};
    int exp4[6] = '{0, 0, 0, 0, 1, 1};

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FS:0] make_flit(input int r, input int p, input int i, input bit t);
        logic [FS:0] f;
        f              = '0;
        f[FS-1]        = t;
        f[7:0]         = i[7:0];
        f[15:8]        = p[7:0];
        f[19:16]       = r[3:0];
        f[FS-2 -: 8]   = 8'h5A ^ 8'(r * 17 + i);
        f[40 +: 16]    = 16'hC3A5 ^ 16'(p * 257);
        return f;
    endfunction

    function automatic bit pending();
        for (int r = 0; r < N; r++) if (npk[r] > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic load(input int r, input int pl, input int np, input int g);
        plen[r] = pl; npk[r] = np; idx[r] = 0; gap[r] = g; bub[r] = 1'b0;
    endtask

    task automatic drive_inputs();
        for (int r = 0; r < N; r++) begin
            if (npk[r] > 0 && !bub[r]) begin
                bus.req_valid[r] = 1'b1;
                bus.req_flit[r*FW +: FW] = make_flit(r, seq[r], idx[r], idx[r] == plen[r] - 1);
            end else begin
                bus.req_valid[r] = 1'b0;
                bus.req_flit[r*FW +: FW] = '0;
            end
        end
    endtask

    // One clock: queue flits that will be accepted at the coming edge, then advance requesters.
    task automatic tick(input bit ret);
        bit x[N];
        logic [FS:0] f;
        bus.credit_ret = ret | (auto_ret && bus.credit_cnt < C);
        for (int r = 0; r < N; r++) begin
            x[r] = bus.req_valid[r] & bus.req_ready[r];
            if (x[r]) begin
                f = make_flit(r, seq[r], idx[r], idx[r] == plen[r] - 1);
                f[FS] = 1'b1;
                exp_q.push_back(f);
            end
        end
        @(negedge clk); #1;
        bus.credit_ret = 1'b0;
        for (int r = 0; r < N; r++) begin
            bub[r] = 1'b0;
            if (x[r]) begin
                if (idx[r] == plen[r] - 1) begin
                    idx[r] = 0; npk[r]--; seq[r]++;
                end else begin
                    idx[r]++;
                end
                if (gap[r] == idx[r] && idx[r] > 0) begin
                    bub[r] = 1'b1; gap[r] = -1;
                end
            end
        end
        drive_inputs();
    endtask

    task automatic run_idle(input int budget);
        int b;
        b = budget;
        while (b > 0 && (pending() || exp_q.size() != 0)) begin
            tick(1'b0);
            b--;
        end
        chk("drain_timeout", pending() || exp_q.size() != 0, 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("ready_onehot0", $onehot0(bus.req_ready), 1);
            if (bus.inject_flit !== '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_flit", bus.inject_flit, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("flit", bus.inject_flit, mon_e);
                end
                out_src.push_back(int'(bus.inject_flit[19:16]));
                out_cyc.push_back(cyc);
                nout++;
            end
        end
    end

    initial begin
        #200000;
        nerr++;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        rst = 1'b0;
        bus.req_valid = '0;
        bus.req_flit = '0;
        bus.credit_ret = 1'b0;
        auto_ret = 1'b0;
        for (int r = 0; r < N; r++) begin
            load(r, 1, 0, -1);
            seq[r] = 0;
        end
        repeat (2) @(negedge clk);
        #1;
        chk("rst_inject", bus.inject_flit, 0);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_credit", bus.credit_cnt, 4);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err_credit_ovf, 0);
        chk("rst_grant", bus.grant_id, 0);
        rst = 1'b1;

        // Three-flit packet from requester 0, no credit returns
        base = nout;
        t0 = cyc;
        load(0, 3, 1, -1);
        drive_inputs();
        tick(1'b0);
        chk("t2_busy_c1", bus.busy, 1);
        chk("t2_ready_c1", bus.req_ready, 4'b0001);
        chk("t2_inject_c1", bus.inject_flit, 0);
        tick(1'b0);
        tick(1'b0);
        chk("t2_busy_c3", bus.busy, 1);
        tick(1'b0);
        chk("t2_busy_c4", bus.busy, 0);
        chk("t2_credit", bus.credit_cnt, 1);
        chk("t2_nflits", nout - base, 3);
        if (nout - base == 3) begin
            chk("t2_first_cycle", out_cyc[base] - t0, 2);
            chk("t2_last_cycle", out_cyc[base+2] - t0, 4);
        end

        // Restore credits, then one return too many
        repeat (3) tick(1'b1);
        chk("t6_credit_full", bus.credit_cnt, 4);
        chk("t6_err_before", bus.err_credit_ovf, 0);
        tick(1'b1);
        chk("t6_credit_sat", bus.credit_cnt, 4);
        chk("t6_err_set", bus.err_credit_ovf, 1);
        repeat (3) tick(1'b0);
        chk("t6_err_sticky", bus.err_credit_ovf, 1);

        // Reset asserted in the middle of a packet
        load(0, 5, 1, -1);
        drive_inputs();
        repeat (3) tick(1'b0);
        chk("t1_busy_pre", bus.busy, 1);
        rst = 1'b0;
        #1;
        chk("t1_inject", bus.inject_flit, 0);
        chk("t1_ready", bus.req_ready, 0);
        chk("t1_credit", bus.credit_cnt, 4);
        chk("t1_busy", bus.busy, 0);
        chk("t1_err", bus.err_credit_ovf, 0);
        for (int r = 0; r < N; r++) load(r, 1, 0, -1);
        drive_inputs();
        exp_q.delete();
        @(negedge clk); #1;
        rst = 1'b1;

        // All four requesters with single-flit packets
        base = out_src.size();
        auto_ret = 1'b1;
        for (int r = 0; r < N; r++) load(r, 1, (r == 0) ? 2 : 1, -1);
        drive_inputs();
        run_idle(40);
        chk("t3_count", out_src.size() - base, 5);
        if (out_src.size() - base == 5) begin
            for (int k = 0; k < 5; k++) chk("t3_order", out_src[base+k], exp3[k]);
            for (int k = 1; k < 5; k++) chk("t3_spacing", out_cyc[base+k] - out_cyc[base+k-1], 2);
        end

        // Four-flit packet with a valid bubble while requester 1 waits
        base = out_src.size();
        load(0, 4, 1, 2);
        drive_inputs();
        tick(1'b0);
        load(1, 2, 1, -1);
        drive_inputs();
        run_idle(40);
        chk("t4_count", out_src.size() - base, 6);
        if (out_src.size() - base == 6) begin
            for (int k = 0; k < 6; k++) chk("t4_order", out_src[base+k], exp4[k]);
            chk("t4_bubble", out_cyc[base+2] - out_cyc[base+1], 2);
            chk("t4_handover", out_cyc[base+4] - out_cyc[base+3], 2);
        end

        // Six-flit packet exhausting credits
        auto_ret = 1'b0;
        for (int k = 0; k < 8 && bus.credit_cnt < C; k++) tick(1'b1);
        chk("t5_credit_start", bus.credit_cnt, 4);
        base = nout;
        load(2, 6, 1, -1);
        drive_inputs();
        repeat (5) tick(1'b0);
        chk("t5_credit_zero", bus.credit_cnt, 0);
        chk("t5_ready_stall", bus.req_ready, 0);
        chk("t5_busy_stall", bus.busy, 1);
        chk("t5_four_flits", nout - base, 4);
        repeat (2) tick(1'b0);
        chk("t5_still_stalled", bus.req_ready, 0);
        chk("t5_no_extra", nout - base, 4);
        tick(1'b1);
        chk("t5_ret_credit", bus.credit_cnt, 1);
        chk("t5_ret_ready", bus.req_ready, 4'b0100);
        tick(1'b0);
        chk("t5_credit_used", bus.credit_cnt, 0);
        tick(1'b0);
        chk("t5_one_released", nout - base, 5);
        chk("t5_ready_again0", bus.req_ready, 0);
        tick(1'b1);
        tick(1'b1);
        chk("t5_credit_const", bus.credit_cnt, 1);
        chk("t5_busy_end", bus.busy, 0);
        tick(1'b0);
        chk("t5_all_flits", nout - base, 6);
        chk("sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
